instr_mem_banked: RTL and testbench

INSTR_MEM_BANKED -- requirements
Module: instr_mem_banked

---
 rtl/instr_mem_pkg.sv | 21 ++
 rtl/instr_mem_banked_ram_1p.sv | 30 +++
 rtl/instr_mem_banked.sv | 158 +++++++++++++++
 tb/tb_instr_mem_banked.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_mem_pkg.sv
// Shared types and defaults for the banked instruction memory.
// Holds the control FSM encoding, the NOP word and parameter defaults.
package instr_mem_pkg;

  localparam int DATA_W_DEF     = 32;
  localparam int ADDR_W_DEF     = 10;
  localparam int BANK_DEPTH_DEF = 256;
  localparam int BANKS_DEF      = 4;

  localparam logic [31:0] NOP = 32'h0000_0000;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  function automatic int bank_w(input int banks);
    return (banks > 1) ? $clog2(banks) : 1;
  endfunction

endpackage

// File: rtl/instr_mem_banked_ram_1p.sv
// Single-port RAM, synchronous read with read enable, no reset.
// Read data holds its value on cycles without a read.
module ram_1p #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int AW     = 10
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/instr_mem_banked.sv
// Banked instruction memory: loader, bulk clear and fetch port
// sharing one single-port array (clear > load > fetch).
module instr_mem_banked
  import instr_mem_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int BANK_DEPTH = BANK_DEPTH_DEF,
  parameter int BANKS      = BANKS_DEF,
  parameter int BANK_W     = bank_w(BANKS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [BANK_W-1:0] ld_bank,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_err,
  input  logic              clr_start,
  output logic              busy,
  input  logic [BANK_W-1:0] prog_sel,
  input  logic              fetch_req,
  output logic              fetch_ready,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instrucao,
  output logic              fault
);

  localparam int TOTAL = BANKS * BANK_DEPTH;
  localparam int PA_W  = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam logic [PA_W-1:0] LAST = PA_W'(TOTAL - 1);

  state_e state_q, state_d;
  logic [PA_W-1:0] cnt_q, cnt_d;
  logic valid_q, valid_d;
  logic fault_q, fault_d;
  logic err_q, err_d;
  logic src_q, src_d;

  logic idle;
  logic ld_acc, fetch_acc;
  logic ld_oor, f_oor;
  logic [PA_W-1:0] ld_pa, f_pa;

  logic              ram_we;
  logic              ram_re;
  logic [PA_W-1:0]   ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  assign idle = (state_q == ST_IDLE);

  // Nothing is accepted while reset is held, so no write slips in.
  assign ld_ready    = idle & ~clr_start & ~reset;
  assign fetch_ready = idle & ~clr_start & ~ld_valid & ~reset;

  assign ld_acc    = ld_valid & ld_ready;
  assign fetch_acc = fetch_req & fetch_ready;

  assign ld_oor = (int'(ld_addr) >= BANK_DEPTH)
                || (int'(ld_bank) >= BANKS);
  assign f_oor  = (int'(fetch_addr) >= BANK_DEPTH)
                || (int'(prog_sel) >= BANKS);

  assign ld_pa = PA_W'(ld_bank) * PA_W'(BANK_DEPTH)
               + PA_W'(ld_addr);
  assign f_pa  = PA_W'(prog_sel) * PA_W'(BANK_DEPTH)
               + PA_W'(fetch_addr);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (clr_start) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end else if (ld_acc) begin
          ram_we    = ~ld_oor;
          ram_addr  = ld_pa;
          ram_wdata = ld_data;
        end else if (fetch_acc) begin
          ram_re   = ~f_oor;
          ram_addr = f_pa;
        end
      end
      ST_CLEAR: begin
        ram_we   = 1'b1;
        ram_addr = cnt_q;
        if (cnt_q == LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // src_q picks RAM data vs NOP; RAM rdata only moves on a real read.
  always_comb begin
    valid_d = fetch_acc;
    fault_d = fetch_acc & f_oor;
    err_d   = ld_acc & ld_oor;
    src_d   = src_q;
    if (fetch_acc) begin
      src_d = ~f_oor;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
      err_q   <= 1'b0;
      src_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
      err_q   <= err_d;
      src_q   <= src_d;
    end
  end

  ram_1p #(
    .DATA_W (DATA_W),
    .DEPTH  (TOTAL),
    .AW     (PA_W)
  ) u_ram (
    .clk_i   (clock),
    .we_i    (ram_we),
    .re_i    (ram_re),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  assign busy        = (state_q == ST_CLEAR);
  assign ld_err      = err_q;
  assign instr_valid = valid_q;
  assign fault       = fault_q;
  assign instrucao   = src_q ? ram_rdata : DATA_W'(NOP);

endmodule

// File: tb/tb_instr_mem_banked.sv
// Directed and randomized bench for instr_mem_banked against a
// flat-array memory model.
module tb_instr_mem_banked;

  localparam int DW    = 32;
  localparam int AW    = 10;
  localparam int DEPTH = 256;
  localparam int NB    = 4;
  localparam int BW    = 2;
  localparam int TOT   = NB * DEPTH;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          ld_valid = 1'b0;
  logic          ld_ready;
  logic [BW-1:0] ld_bank = '0;
  logic [AW-1:0] ld_addr = '0;
  logic [DW-1:0] ld_data = '0;
  logic          ld_err;
  logic          clr_start = 1'b0;
  logic          busy;
  logic [BW-1:0] prog_sel = '0;
  logic          fetch_req = 1'b0;
  logic          fetch_ready;
  logic [AW-1:0] fetch_addr = '0;
  logic          instr_valid;
  logic [DW-1:0] instrucao;
  logic          fault;

  always #5 clock = ~clock;

  instr_mem_banked dut (
    .clock       (clock),
    .reset       (reset),
    .ld_valid    (ld_valid),
    .ld_ready    (ld_ready),
    .ld_bank     (ld_bank),
    .ld_addr     (ld_addr),
    .ld_data     (ld_data),
    .ld_err      (ld_err),
    .clr_start   (clr_start),
    .busy        (busy),
    .prog_sel    (prog_sel),
    .fetch_req   (fetch_req),
    .fetch_ready (fetch_ready),
    .fetch_addr  (fetch_addr),
    .instr_valid (instr_valid),
    .instrucao   (instrucao),
    .fault       (fault)
  );

  logic [31:0] mdl [TOT];
  bit          known [TOT];
  logic [31:0] last_instr = '0;
  bit          last_ok = 1'b1;
  int          passed = 0;
  int          failed = 0;
  int          total  = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit oor(input int b, input int a);
    return (a >= DEPTH) || (b >= NB);
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic mdl_write(input int b, input int a, input logic [31:0] d);
    if (!oor(b, a)) begin
      mdl[b * DEPTH + a]   = d;
      known[b * DEPTH + a] = 1'b1;
    end
  endtask

  // Expected instrucao after a fetch of (b, a); updates the held value.
  task automatic mdl_fetch(input int b, input int a);
    if (oor(b, a)) begin
      last_instr = '0;
      last_ok    = 1'b1;
    end else begin
      last_instr = mdl[b * DEPTH + a];
      last_ok    = known[b * DEPTH + a];
    end
  endtask

  task automatic do_load(input int b, input int a, input logic [31:0] d,
                         input string tag);
    ld_valid  = 1'b1;
    ld_bank   = BW'(b);
    ld_addr   = AW'(a);
    ld_data   = d;
    fetch_req = 1'b0;
    clr_start = 1'b0;
    #1;
    chk({tag, "/ld_ready"}, 32'(ld_ready), 32'd1);
    tick();
    ld_valid = 1'b0;
    chk({tag, "/ld_err"}, 32'(ld_err), 32'(oor(b, a)));
    mdl_write(b, a, d);
  endtask

  task automatic do_fetch(input int b, input int a, input string tag);
    fetch_req  = 1'b1;
    prog_sel   = BW'(b);
    fetch_addr = AW'(a);
    ld_valid   = 1'b0;
    clr_start  = 1'b0;
    #1;
    chk({tag, "/fetch_ready"}, 32'(fetch_ready), 32'd1);
    tick();
    fetch_req  = 1'b0;
    prog_sel   = BW'($urandom);
    fetch_addr = AW'($urandom);
    mdl_fetch(b, a);
    chk({tag, "/valid"}, 32'(instr_valid), 32'd1);
    chk({tag, "/fault"}, 32'(fault), 32'(oor(b, a)));
    if (last_ok) chk({tag, "/instr"}, instrucao, last_instr);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int bad;
    bit ldv;
    bit fr;
    int lb, la, fb, fa;
    logic [31:0] d;
    bit exp_fault;

    for (int i = 0; i < TOT; i++) begin
      mdl[i]   = '0;
      known[i] = 1'b0;
    end

    #2;
    chk("rst/valid", 32'(instr_valid), 32'd0);
    chk("rst/fault", 32'(fault), 32'd0);
    chk("rst/ld_err", 32'(ld_err), 32'd0);
    chk("rst/instr", instrucao, 32'd0);
    chk("rst/busy", 32'(busy), 32'd0);
    @(negedge clock);
    reset = 1'b0;

    do_load(1, 5, 32'h8C01_0001, "r38_ld");
    do_fetch(1, 5, "r38_f");

    do_load(1, 44, 32'hCAFE_0044, "r39_pre");
    do_fetch(0, 300, "r39_f");
    do_load(0, 300, 32'hDEAD_BEEF, "r39_ld");
    tick();
    chk("r39/err_pulse", 32'(ld_err), 32'd0);
    chk("r39/idle_valid", 32'(instr_valid), 32'd0);
    chk("r39/hold_instr", instrucao, 32'd0);
    do_fetch(1, 44, "r39_alias");

    ld_valid   = 1'b1;
    ld_bank    = 2'd2;
    ld_addr    = 10'd7;
    ld_data    = 32'h1234_5677;
    fetch_req  = 1'b1;
    prog_sel   = 2'd2;
    fetch_addr = 10'd7;
    #1;
    chk("r41/ld_ready", 32'(ld_ready), 32'd1);
    chk("r41/fetch_ready", 32'(fetch_ready), 32'd0);
    tick();
    ld_valid = 1'b0;
    mdl_write(2, 7, 32'h1234_5677);
    chk("r41/no_valid", 32'(instr_valid), 32'd0);
    do_fetch(2, 7, "r41_f");

    for (int i = 0; i < 3; i++) do_load(0, i, 32'hA000_0000 + i, "r43_ld");
    for (int i = 0; i < 3; i++) do_fetch(0, i, "r43_f");

    clr_start  = 1'b1;
    ld_valid   = 1'b1;
    fetch_req  = 1'b1;
    ld_addr    = 10'd3;
    fetch_addr = 10'd3;
    #1;
    chk("r40/ld_ready", 32'(ld_ready), 32'd0);
    chk("r40/fetch_ready", 32'(fetch_ready), 32'd0);
    tick();
    clr_start = 1'b0;
    n   = 0;
    bad = 0;
    while (busy && n < 2000) begin
      n++;
      if (ld_ready || fetch_ready) bad++;
      tick();
    end
    ld_valid  = 1'b0;
    fetch_req = 1'b0;
    chk("r40/busy_cycles", 32'(n), 32'd1024);
    chk("r40/ready_in_clear", 32'(bad), 32'd0);
    for (int i = 0; i < TOT; i++) begin
      mdl[i]   = '0;
      known[i] = 1'b1;
    end
    for (int i = 0; i < 6; i++)
      do_fetch($urandom_range(0, 3), $urandom_range(0, 255), "r40_f");

    for (int i = 0; i < 400; i++) begin
      ldv = ($urandom_range(0, 2) == 0);
      fr  = ($urandom_range(0, 1) == 1);
      lb  = $urandom_range(0, 3);
      fb  = $urandom_range(0, 3);
      la  = ($urandom_range(0, 4) == 0) ? $urandom_range(256, 1023)
                                        : $urandom_range(0, 255);
      fa  = ($urandom_range(0, 4) == 0) ? $urandom_range(256, 1023)
                                        : $urandom_range(0, 255);
      d   = $urandom;
      ld_valid   = ldv;
      ld_bank    = BW'(lb);
      ld_addr    = AW'(la);
      ld_data    = d;
      fetch_req  = fr;
      prog_sel   = BW'(fb);
      fetch_addr = AW'(fa);
      #1;
      chk("rnd/ld_ready", 32'(ld_ready), 32'd1);
      chk("rnd/fetch_ready", 32'(fetch_ready), 32'(!ldv));
      exp_fault = 1'b0;
      if (fr && !ldv) begin
        mdl_fetch(fb, fa);
        exp_fault = oor(fb, fa);
      end
      tick();
      chk("rnd/ld_err", 32'(ld_err), 32'(ldv && oor(lb, la)));
      chk("rnd/valid", 32'(instr_valid), 32'(fr && !ldv));
      chk("rnd/fault", 32'(fault), 32'(exp_fault));
      chk("rnd/instr", instrucao, last_instr);
      if (ldv) mdl_write(lb, la, d);
    end
    ld_valid  = 1'b0;
    fetch_req = 1'b0;

    do_load(0, 200, 32'h0200_0200, "r42_ld");
    do_load(0, 150, 32'h0150_0150, "r42_ld");
    do_load(0, 100, 32'h0100_0100, "r42_ld");
    do_load(0, 99, 32'h0099_0099, "r42_ld");
    do_load(0, 50, 32'h0050_0050, "r42_ld");
    do_load(0, 0, 32'h0000_0001, "r42_ld");
    do_fetch(0, 200, "r42_pre");
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    repeat (100) tick();
    chk("r42/busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("r42/busy", 32'(busy), 32'd0);
    chk("r42/valid", 32'(instr_valid), 32'd0);
    chk("r42/fault", 32'(fault), 32'd0);
    chk("r42/ld_err", 32'(ld_err), 32'd0);
    chk("r42/instr", instrucao, 32'd0);
    last_instr = '0;
    for (int i = 0; i < 100; i++) mdl[i] = '0;
    @(negedge clock);
    reset = 1'b0;
    do_fetch(0, 0, "r42_w0");
    do_fetch(0, 50, "r42_w50");
    do_fetch(0, 99, "r42_w99");
    do_fetch(0, 100, "r42_w100");
    do_fetch(0, 150, "r42_w150");
    do_fetch(0, 200, "r42_w200");
    for (int i = 0; i < 8; i++)
      do_fetch($urandom_range(0, 3), $urandom_range(0, 255), "r42_rnd");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
